// File: rtl/atm_session_if.sv
// atm_session_if: front-end/actuator bundle between the card/keypad side and the ATM controller.
// master: card reader, keypad and actuator side; drives the requests and observes the controller outputs.
// slave:  the controller; takes card/pin/choice/amount requests and drives accept/dispense/balance/status.
interface atm_session_if #(
    parameter int PIN_W     = 4,
    parameter int NUM_DENOM = 3,
    parameter int BAL_W     = 16
);
    localparam int AMT_W = $clog2(NUM_DENOM + 1);
    logic                 card;
    logic                 pin_valid;
    logic [PIN_W-1:0]     pin;
    logic [PIN_W-1:0]     stored_pin;
    logic                 choice_valid;
    logic                 choice;
    logic                 amount_valid;
    logic [AMT_W-1:0]     amount;
    logic [NUM_DENOM-1:0] accept;
    logic [NUM_DENOM-1:0] dispense;
    logic [BAL_W-1:0]     balance;
    logic                 error;
    logic                 eject;
    logic                 retained;
    logic [2:0]           state_o;
    modport master (
        output card, pin_valid, pin, stored_pin, choice_valid, choice, amount_valid, amount,
        input  accept, dispense, balance, error, eject, retained, state_o
    );
    modport slave (
        input  card, pin_valid, pin, stored_pin, choice_valid, choice, amount_valid, amount,
        output accept, dispense, balance, error, eject, retained, state_o
    );
endinterface

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: ATM session FSM with PIN retries, deposit/withdraw, guarded balance and idle timeout.
// Ports: clock (rising edge), reset_n (async active-low), bus (atm_session_if.slave):
//   inputs  card, pin_valid/pin/stored_pin, choice_valid/choice, amount_valid/amount
//   outputs accept/dispense (one-hot pulses), balance, error (pulse), eject, retained, state_o
module atm_session_ctrl #(
    parameter int          PIN_W     = 4,
    parameter int          MAX_TRIES = 3,
    parameter int          NUM_DENOM = 3,
    parameter int          BAL_W     = 16,
    parameter logic [15:0] INIT_BAL  = 16'd4,
    parameter int          TIMEOUT   = 15
) (
    input logic          clock,
    input logic          reset_n,
    atm_session_if.slave bus
);
    localparam int AMT_W = $clog2(NUM_DENOM + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, CARD_IN, MENU, DEPOSIT, WITHDRAW, EJECT, RETAIN} state_t;
    state_t               state, state_n;
    logic [TRY_W-1:0]     tries, tries_n, tries_inc;
    logic [TMR_W-1:0]     timer, timer_n;
    logic [BAL_W-1:0]     balance, bal_n;
    logic [NUM_DENOM-1:0] accept, dispense, acc_n, disp_n, one_hot;
    logic                 error, err_n, eject, retained;
    logic                 active, strobe, amt_ok, timeout_hit;
    logic [BAL_W:0]       denom, sum;
    assign active      = state inside {CARD_IN, MENU, DEPOSIT, WITHDRAW};
    assign strobe      = bus.pin_valid | bus.choice_valid | bus.amount_valid;
    assign amt_ok      = bus.amount != '0 && bus.amount <= AMT_W'(NUM_DENOM);
    assign denom       = amt_ok ? (BAL_W+1)'(1) << (bus.amount - AMT_W'(1)) : '0;
    assign one_hot     = NUM_DENOM'(1) << (bus.amount - AMT_W'(1));
    // the extra top bit of sum flags a deposit that would exceed the balance range
    assign sum         = {1'b0, balance} + denom;
    assign tries_inc   = tries + TRY_W'(1);
    assign timeout_hit = active && timer == TMR_W'(TIMEOUT - 1);
    always_comb begin
        state_n = state;
        tries_n = tries;
        bal_n   = balance;
        acc_n   = '0;
        disp_n  = '0;
        err_n   = 1'b0;
        if (active && !bus.card) begin
            state_n = IDLE;
        end else if (timeout_hit) begin
            state_n = EJECT;
            err_n   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tries_n = '0;
                    state_n = bus.card ? CARD_IN : IDLE;
                end
                CARD_IN: if (bus.pin_valid) begin
                    if (bus.pin == bus.stored_pin) begin
                        state_n = MENU;
                        tries_n = '0;
                    end else begin
                        err_n   = 1'b1;
                        tries_n = tries_inc;
                        state_n = tries_inc == TRY_W'(MAX_TRIES) ? RETAIN : CARD_IN;
                    end
                end
                MENU: if (bus.choice_valid) state_n = bus.choice ? WITHDRAW : DEPOSIT;
                DEPOSIT: if (bus.amount_valid) begin
                    if (!amt_ok || sum[BAL_W]) begin
                        err_n = 1'b1;
                    end else begin
                        acc_n   = one_hot;
                        bal_n   = sum[BAL_W-1:0];
                        state_n = EJECT;
                    end
                end
                WITHDRAW: if (bus.amount_valid) begin
                    if (!amt_ok || {1'b0, balance} < denom) begin
                        err_n = 1'b1;
                    end else begin
                        disp_n  = one_hot;
                        bal_n   = balance - denom[BAL_W-1:0];
                        state_n = EJECT;
                    end
                end
                EJECT, RETAIN: if (!bus.card) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
        // the idle timer restarts on any strobe or state change and only runs in active states
        timer_n = (state_n != state || strobe || !active) ? '0 : timer + TMR_W'(1);
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tries    <= '0;
            timer    <= '0;
            balance  <= BAL_W'(INIT_BAL);
            accept   <= '0;
            dispense <= '0;
            error    <= 1'b0;
            eject    <= 1'b0;
            retained <= 1'b0;
        end else begin
            state    <= state_n;
            tries    <= tries_n;
            timer    <= timer_n;
            balance  <= bal_n;
            accept   <= acc_n;
            dispense <= disp_n;
            error    <= err_n;
            eject    <= state_n == EJECT;
            retained <= state_n == RETAIN;
        end
    end
    assign bus.accept   = accept;
    assign bus.dispense = dispense;
    assign bus.balance  = balance;
    assign bus.error    = error;
    assign bus.eject    = eject;
    assign bus.retained = retained;
    assign bus.state_o  = state;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: table-driven scoreboard bench for atm_session_ctrl (two instances, different INIT_BAL).
module tb_atm_session_ctrl;
    localparam logic [2:0] IDLE = 3'd0, CARD_IN = 3'd1, MENU = 3'd2, DEPOSIT = 3'd3;
    localparam logic [2:0] WITHDRAW = 3'd4, EJECT = 3'd5, RETAIN = 3'd6;
    typedef struct {
        bit          sel;
        bit          card, pv;
        logic [3:0]  pin;
        bit          cv, ch, av;
        logic [1:0]  amt;
        logic [27:0] exp;
    } vec_t;
    typedef struct {
        string       name;
        bit          sel;
        int          due;
        logic [27:0] exp;
    } sb_t;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    sb_t  sb[$];
    vec_t tv[$];
    atm_session_if #(.PIN_W(4), .NUM_DENOM(3), .BAL_W(16)) ifa ();
    atm_session_if #(.PIN_W(4), .NUM_DENOM(3), .BAL_W(16)) ifb ();
    atm_session_ctrl #(.INIT_BAL(16'd4)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ifa));
    atm_session_ctrl #(.INIT_BAL(16'hFFFD)) dut_b (.clock(clock), .reset_n(reset_n), .bus(ifb));
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    // expected packing: {state, accept, dispense, error, eject, retained, balance}
    function automatic logic [27:0] ex(input logic [2:0] st, input logic [2:0] acc, input logic [2:0] disp,
                                       input bit err, input bit ej, input bit ret, input logic [15:0] bal);
        return {st, acc, disp, err, ej, ret, bal};
    endfunction
    function automatic vec_t mk(input bit sel, input bit card, input bit pv, input logic [3:0] pin,
                                input bit cv, input bit ch, input bit av, input logic [1:0] amt,
                                input logic [27:0] exp);
        return vec_t'{sel, card, pv, pin, cv, ch, av, amt, exp};
    endfunction
    function automatic logic [27:0] act(input bit sel);
        return sel ? {ifb.state_o, ifb.accept, ifb.dispense, ifb.error, ifb.eject, ifb.retained, ifb.balance}
                   : {ifa.state_o, ifa.accept, ifa.dispense, ifa.error, ifa.eject, ifa.retained, ifa.balance};
    endfunction
    task automatic chk(input string name, input logic [27:0] got, input logic [27:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (st,acc,disp,err,ej,ret,bal)", name, got, exp);
        end
    endtask
    task automatic drive(input bit sel, input bit card, input bit pv, input logic [3:0] pin,
                         input bit cv, input bit ch, input bit av, input logic [1:0] amt);
        {ifa.card, ifa.pin_valid, ifa.pin, ifa.choice_valid, ifa.choice, ifa.amount_valid, ifa.amount} = '0;
        {ifb.card, ifb.pin_valid, ifb.pin, ifb.choice_valid, ifb.choice, ifb.amount_valid, ifb.amount} = '0;
        if (sel) {ifb.card, ifb.pin_valid, ifb.pin, ifb.choice_valid, ifb.choice, ifb.amount_valid, ifb.amount}
                 = {card, pv, pin, cv, ch, av, amt};
        else     {ifa.card, ifa.pin_valid, ifa.pin, ifa.choice_valid, ifa.choice, ifa.amount_valid, ifa.amount}
                 = {card, pv, pin, cv, ch, av, amt};
    endtask
    task automatic step(input string name, input vec_t v);
        @(negedge clock);
        drive(v.sel, v.card, v.pv, v.pin, v.cv, v.ch, v.av, v.amt);
        sb.push_back(sb_t'{name, v.sel, cyc + 1, v.exp});
    endtask
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].due == cyc) begin
            sb_t e;
            e = sb.pop_front();
            chk(e.name, act(e.sel), e.exp);
        end
    end
    initial begin
        ifa.stored_pin = 4'h5;
        ifb.stored_pin = 4'h5;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // successful withdraw of code 2 (2 units) from 4
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(IDLE, 0, 0, 0, 0, 0, 4)));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, ex(CARD_IN, 0, 0, 0, 0, 0, 4)));
        tv.push_back(mk(0, 1, 1, 5, 0, 0, 0, 0, ex(MENU, 0, 0, 0, 0, 0, 4)));
        tv.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, ex(WITHDRAW, 0, 0, 0, 0, 0, 4)));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 1, 2, ex(EJECT, 0, 3'b010, 0, 1, 0, 2)));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, ex(EJECT, 0, 0, 0, 1, 0, 2)));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(IDLE, 0, 0, 0, 0, 0, 2)));
        // three wrong PINs retain the card; later strobes are ignored
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, ex(CARD_IN, 0, 0, 0, 0, 0, 2)));
        tv.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, ex(CARD_IN, 0, 0, 1, 0, 0, 2)));
        tv.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, ex(CARD_IN, 0, 0, 1, 0, 0, 2)));
        tv.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, ex(RETAIN, 0, 0, 1, 0, 1, 2)));
        tv.push_back(mk(0, 1, 1, 5, 0, 0, 0, 0, ex(RETAIN, 0, 0, 0, 0, 1, 2)));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(IDLE, 0, 0, 0, 0, 0, 2)));
        // insufficient funds, then a smaller withdraw
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, ex(CARD_IN, 0, 0, 0, 0, 0, 2)));
        tv.push_back(mk(0, 1, 1, 5, 0, 0, 0, 0, ex(MENU, 0, 0, 0, 0, 0, 2)));
        tv.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, ex(WITHDRAW, 0, 0, 0, 0, 0, 2)));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, ex(WITHDRAW, 0, 0, 1, 0, 0, 2)));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, ex(EJECT, 0, 3'b001, 0, 1, 0, 1)));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(IDLE, 0, 0, 0, 0, 0, 1)));
        // overflow guard on the near-full instance
        tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, ex(CARD_IN, 0, 0, 0, 0, 0, 16'hFFFD)));
        tv.push_back(mk(1, 1, 1, 5, 0, 0, 0, 0, ex(MENU, 0, 0, 0, 0, 0, 16'hFFFD)));
        tv.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, ex(DEPOSIT, 0, 0, 0, 0, 0, 16'hFFFD)));
        tv.push_back(mk(1, 1, 0, 0, 0, 0, 1, 3, ex(DEPOSIT, 0, 0, 1, 0, 0, 16'hFFFD)));
        tv.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, ex(EJECT, 3'b001, 0, 0, 1, 0, 16'hFFFE)));
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, ex(IDLE, 0, 0, 0, 0, 0, 16'hFFFE)));
        repeat (3) @(posedge clock);
        #1;
        chk("reset_a", act(0), ex(IDLE, 0, 0, 0, 0, 0, 4));
        chk("reset_b", act(1), ex(IDLE, 0, 0, 0, 0, 0, 16'hFFFD));
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < tv.size(); i++) step($sformatf("vec%0d", i), tv[i]);
        // inactivity timeout in MENU: 14 idle cycles stay, the 15th ejects with an error
        step("to_card", mk(0, 1, 0, 0, 0, 0, 0, 0, ex(CARD_IN, 0, 0, 0, 0, 0, 1)));
        step("to_pin", mk(0, 1, 1, 5, 0, 0, 0, 0, ex(MENU, 0, 0, 0, 0, 0, 1)));
        for (int i = 0; i < 14; i++)
            step($sformatf("to_wait%0d", i), mk(0, 1, 0, 0, 0, 0, 0, 0, ex(MENU, 0, 0, 0, 0, 0, 1)));
        step("to_fire", mk(0, 1, 0, 0, 0, 0, 0, 0, ex(EJECT, 0, 0, 1, 1, 0, 1)));
        step("to_out", mk(0, 0, 0, 0, 0, 0, 0, 0, ex(IDLE, 0, 0, 0, 0, 0, 1)));
        // invalid amount code 0 in DEPOSIT, then a valid deposit
        step("d0_card", mk(0, 1, 0, 0, 0, 0, 0, 0, ex(CARD_IN, 0, 0, 0, 0, 0, 1)));
        step("d0_pin", mk(0, 1, 1, 5, 0, 0, 0, 0, ex(MENU, 0, 0, 0, 0, 0, 1)));
        step("d0_menu", mk(0, 1, 0, 0, 1, 0, 0, 0, ex(DEPOSIT, 0, 0, 0, 0, 0, 1)));
        step("d0_zero", mk(0, 1, 0, 0, 0, 0, 1, 0, ex(DEPOSIT, 0, 0, 1, 0, 0, 1)));
        step("d0_one", mk(0, 1, 0, 0, 0, 0, 1, 1, ex(EJECT, 3'b001, 0, 0, 1, 0, 2)));
        step("d0_out", mk(0, 0, 0, 0, 0, 0, 0, 0, ex(IDLE, 0, 0, 0, 0, 0, 2)));
        // card pulled in the same cycle as a withdraw request
        step("cd_card", mk(0, 1, 0, 0, 0, 0, 0, 0, ex(CARD_IN, 0, 0, 0, 0, 0, 2)));
        step("cd_pin", mk(0, 1, 1, 5, 0, 0, 0, 0, ex(MENU, 0, 0, 0, 0, 0, 2)));
        step("cd_menu", mk(0, 1, 0, 0, 1, 1, 0, 0, ex(WITHDRAW, 0, 0, 0, 0, 0, 2)));
        step("cd_pull", mk(0, 0, 0, 0, 0, 0, 1, 1, ex(IDLE, 0, 0, 0, 0, 0, 2)));
        // asynchronous reset in the middle of a deposit
        step("rs_card", mk(0, 1, 0, 0, 0, 0, 0, 0, ex(CARD_IN, 0, 0, 0, 0, 0, 2)));
        step("rs_pin", mk(0, 1, 1, 5, 0, 0, 0, 0, ex(MENU, 0, 0, 0, 0, 0, 2)));
        step("rs_menu", mk(0, 1, 0, 0, 1, 0, 0, 0, ex(DEPOSIT, 0, 0, 0, 0, 0, 2)));
        step("rs_hold", mk(0, 1, 0, 0, 0, 0, 0, 0, ex(DEPOSIT, 0, 0, 0, 0, 0, 2)));
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rs_async", act(0), ex(IDLE, 0, 0, 0, 0, 0, 4));
        @(negedge clock);
        reset_n = 1'b1;
        step("rs_after", mk(0, 0, 0, 0, 0, 0, 0, 0, ex(IDLE, 0, 0, 0, 0, 0, 4)));
        repeat (3) @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Parametrised next-generation ATM transaction controller. It handles a full session: card detect, PIN check with a bounded retry count, deposit/withdraw menu, and denomination selection. It also keeps an internal account balance with overdraft and overflow protection, an inactivity timeout, and card eject/retain. It sits between the card/keypad front end and the note acceptor/dispenser actuators.

Parameters:
PIN_W, 4, PIN width in bits
MAX_TRIES, 3, consecutive wrong PINs before the card is retained (>=1)
NUM_DENOM, 3, number of note denominations; code k (1..NUM_DENOM) = 2^(k-1) units of 50000
BAL_W, 16, balance width in 50000-units
INIT_BAL, 4, balance value loaded at reset
TIMEOUT, 15, idle cycles before a forced eject (>=2)
AMT_W (localparam), clog2(NUM_DENOM+1), amount code width

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
card  in  1  card present (level)
pin_valid  in  1  pin qualifier, 1-cycle strobe
pin  in  PIN_W  entered PIN
stored_pin  in  PIN_W  reference PIN for the inserted card
choice_valid  in  1  choice qualifier strobe
choice  in  1  0 = deposit, 1 = withdraw
amount_valid  in  1  amount qualifier strobe
amount  in  AMT_W  denomination code; 0 = invalid
accept  out  NUM_DENOM  one-hot, 1-cycle deposit-accepted pulse
dispense  out  NUM_DENOM  one-hot, 1-cycle dispense pulse
balance  out  BAL_W  current balance (registered)
error  out  1  1-cycle pulse on a rejected request
eject  out  1  level, card being returned
retained  out  1  level, card swallowed
state_o  out  3  current state, for debug

Behaviour:
- Reset (async, reset_n=0): state IDLE; accept, dispense, error, eject and retained = 0; balance = INIT_BAL; tries counter = 0; timer = 0. All outputs are registered.
- States: IDLE, CARD_IN, MENU, DEPOSIT, WITHDRAW, EJECT, RETAIN.
- IDLE: card=1 -> CARD_IN next cycle. Tries counter cleared.
- CARD_IN: pin_valid and pin==stored_pin -> MENU, tries cleared. pin_valid and mismatch -> error pulse, tries+1. If the new tries value equals MAX_TRIES -> RETAIN; otherwise stay.
- MENU: choice_valid -> DEPOSIT (choice=0) or WITHDRAW (choice=1).
- DEPOSIT: amount_valid with k in 1..NUM_DENOM:
  - balance + 2^(k-1) <= 2^BAL_W-1 -> accept[k-1] pulse, balance updated the same edge, -> EJECT.
  - Otherwise -> error pulse, balance unchanged, stay in DEPOSIT.
- WITHDRAW: amount_valid with k valid:
  - balance >= 2^(k-1) -> dispense[k-1] pulse, balance -= 2^(k-1), -> EJECT.
  - Otherwise -> error pulse, stay in WITHDRAW.
- amount_valid with code 0 or code > NUM_DENOM -> error pulse, no state or balance change.
- EJECT: eject=1 until card=0, then -> IDLE.
- RETAIN: retained=1 until card=0, then -> IDLE. The retained output remains 1 while in RETAIN.
- Latency: one clock from a qualifying strobe to the state change and output pulse.
- Timer: cleared on every state change and on any pin_valid, choice_valid or amount_valid strobe. Counts in CARD_IN, MENU, DEPOSIT and WITHDRAW. At count TIMEOUT-1 -> EJECT with an error pulse.
- Priority per cycle in active states: card=0 (-> IDLE, no transaction, no pulse) > timeout > valid strobe of the current state.
- Strobes not belonging to the current state are ignored. Several strobes in one cycle: only the current state's strobe acts.
- At most one bit of accept, dispense and error is set in any cycle.
- reset_n asserted mid-session: immediate return to reset values, including balance = INIT_BAL.

Test Plan:
- Card=1, pin=4'h5 with stored=4'h5, choice=1, amount=2 -> dispense=3'b010 one cycle; balance 4->2; EJECT; card=0 -> IDLE.
- Three wrong PINs (pin=1, stored=5) -> three error pulses; RETAIN after the 3rd with retained=1; card=0 -> IDLE.
- Withdraw with amount=3 from balance 2 -> error pulse, dispense=0, balance stays 2; then amount=1 -> dispense=3'b001, balance=1.
- Deposit amount=3 with INIT_BAL=16'hFFFD -> error (overflow), balance unchanged; amount=1 -> accept=3'b001, balance=16'hFFFE.
- Enter MENU and stay idle for 14 cycles -> EJECT with an error pulse; amount=0 in DEPOSIT -> error only, no state change.
- card=0 in WITHDRAW in the same cycle as amount_valid -> IDLE, no dispense; reset_n low mid-DEPOSIT -> IDLE, balance=4.
